// File: rtl/qif_tdm_scheduler.sv
// qif_tdm_scheduler: time-multiplexes one QIF datapath across 4 neuron contexts with a spike FIFO
module qif_tdm_scheduler #(
  parameter logic [15:0] TICK_DIV   = 16'd1000,
  parameter logic [7:0]  DP_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       err_clr,
  output logic       dp_start,
  output logic [7:0] dp_v,
  output logic [7:0] dp_b,
  input  logic       dp_done,
  input  logic [7:0] dp_v_nxt,
  input  logic       dp_spike,
  output logic       spk_valid,
  output logic [1:0] spk_id,
  input  logic       spk_ready,
  output logic [7:0] v_mon,
  output logic       busy,
  output logic       ovf,
  output logic       overrun,
  output logic       timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;
  state_t r_state, w_next;
  logic [15:0] r_tcnt;
  logic [1:0]  r_ctx, w_nctx;
  logic [7:0]  r_v [4];
  logic [7:0]  r_b [4];
  logic [7:0]  r_wcnt, r_cap_v;
  logic        r_cap_s, r_skip;
  logic [1:0]  r_fifo [4];
  logic [1:0]  r_wr, r_rd;
  logic [2:0]  r_cnt;
  logic        w_tick, w_tmo, w_last, w_enter, w_wb, w_push, w_pop, w_full, w_wr;
  assign w_tick    = ena && r_tcnt == TICK_DIV - 16'd1;
  assign w_tmo     = r_state == WAIT && !dp_done && r_wcnt == DP_TIMEOUT - 8'd1;
  assign w_last    = r_ctx == 2'd3;
  assign w_enter   = w_next == ISSUE;
  assign w_nctx    = (r_state == IDLE) ? 2'd0 : r_ctx + 2'd1;
  assign w_wb      = r_state == WRITE && !r_skip;
  assign w_push    = w_wb && r_cap_s;
  assign w_pop     = spk_valid && spk_ready;
  assign w_full    = r_cnt == 3'd4;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign dp_start  = r_state == ISSUE;
  assign spk_valid = r_cnt != 3'd0;
  assign spk_id    = spk_valid ? r_fifo[r_rd] : 2'd0;
  // Round tick counter: free-runs while enabled, frozen otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tcnt <= '0;
    else if (ena) r_tcnt <= w_tick ? 16'd0 : r_tcnt + 16'd1;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // FSM next state; a timeout takes the WRITE path with write-back suppressed
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_tick ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (dp_done || w_tmo) ? WRITE : WAIT;
      WRITE:   w_next = w_last ? IDLE : ISSUE;
      default: w_next = IDLE;
    endcase
  end
  // Context sequencing, operand issue (with same-cycle cfg bypass), result capture and write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctx   <= '0;
      r_wcnt  <= '0;
      r_cap_v <= '0;
      r_cap_s <= 1'b0;
      r_skip  <= 1'b0;
      dp_v    <= '0;
      dp_b    <= '0;
      v_mon   <= '0;
      busy    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_v[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      if (cfg_we) r_b[cfg_addr] <= cfg_data;
      if (w_enter) begin
        r_ctx <= w_nctx;
        dp_v  <= r_v[w_nctx];
        dp_b  <= (cfg_we && cfg_addr == w_nctx) ? cfg_data : r_b[w_nctx];
      end
      if (r_state == IDLE && w_tick) busy <= 1'b1;
      if (r_state == WRITE && w_last) busy <= 1'b0;
      r_wcnt <= (r_state == WAIT) ? r_wcnt + 8'd1 : 8'd0;
      if (r_state == WAIT && dp_done) begin
        r_cap_v <= dp_v_nxt;
        r_cap_s <= dp_spike;
        r_skip  <= 1'b0;
      end
      if (w_tmo) r_skip <= 1'b1;
      if (w_wb) begin
        r_v[r_ctx] <= r_cap_v;
        v_mon      <= r_cap_v;
      end
    end
  end
  // Spike FIFO: a push into a full FIFO only lands when a pop frees a slot in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
    end else begin
      if (w_wr) begin
        r_fifo[r_wr] <= r_ctx;
        r_wr         <= r_wr + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      r_cnt <= r_cnt + {2'b0, w_wr} - {2'b0, w_pop};
    end
  end
  // Sticky error flags; a setting event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf         <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ovf         <= (w_push && w_full && !w_pop) || (ovf && !err_clr);
      overrun     <= (w_tick && busy) || (overrun && !err_clr);
      timeout_err <= w_tmo || (timeout_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_qif_tdm_scheduler.sv
// tb_qif_tdm_scheduler: randomized bench with a transaction-level scheduler/FIFO model and datapath responder
module tb_qif_tdm_scheduler;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, cfg_we = 1'b0, err_clr = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0, dp_v_nxt = '0;
  logic       dp_done = 1'b0, dp_spike = 1'b0, spk_ready = 1'b0;
  logic       dp_start, spk_valid, busy, ovf, overrun, timeout_err;
  logic [7:0] dp_v, dp_b, v_mon;
  logic [1:0] spk_id;
  int n_chk = 0, n_fail = 0;

  qif_tdm_scheduler #(.TICK_DIV(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .err_clr(err_clr), .dp_start(dp_start), .dp_v(dp_v), .dp_b(dp_b), .dp_done(dp_done),
    .dp_v_nxt(dp_v_nxt), .dp_spike(dp_spike), .spk_valid(spk_valid), .spk_id(spk_id),
    .spk_ready(spk_ready), .v_mon(v_mon), .busy(busy), .ovf(ovf), .overrun(overrun),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference model state (one update per clock, evaluated mid-cycle)
  int cyc = 0, m_tcnt, m_ctx, issue_at, done_at, tmo_at, write_at, starts = 0;
  int lat_fix = 2, drop_ctx = -1;
  bit force_spk = 0, rnd_drop = 0;
  bit m_busy, m_in_wait, m_ovf, m_ovr, m_tmo, cap_s, skip;
  bit b, tick, pop, push, full, ovf_s, ovr_s, tmo_s;
  logic [7:0] mv [4];
  logic [7:0] mb [4];
  logic [7:0] m_vmon, op_v, op_b, cap_v;
  logic [8:0] sum;
  int mq [$];

  task automatic model_reset();
    m_tcnt = 0; m_ctx = 0; issue_at = -1; done_at = -1; tmo_at = -1; write_at = -1;
    m_busy = 0; m_in_wait = 0; m_ovf = 0; m_ovr = 0; m_tmo = 0; cap_s = 0; skip = 0;
    m_vmon = 0; cap_v = 0; op_v = 0; op_b = 0;
    for (int i = 0; i < 4; i++) begin mv[i] = 0; mb[i] = 0; end
    mq.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      dp_done = 1'b0;
      if (!rst_n) model_reset();
      else begin
        chk("busy", busy, m_busy);
        chk("dp_start", dp_start, cyc == issue_at);
        chk("spk_valid", spk_valid, mq.size() != 0);
        if (mq.size() != 0) chk("spk_id", spk_id, mq[0]);
        chk("v_mon", v_mon, m_vmon);
        chk("ovf", ovf, m_ovf);
        chk("overrun", overrun, m_ovr);
        chk("timeout_err", timeout_err, m_tmo);
        ovf_s = 0; ovr_s = 0; tmo_s = 0;
        if (cyc == issue_at) begin
          starts++;
          op_v = mv[m_ctx];
          op_b = mb[m_ctx];
          chk("dp_v", dp_v, op_v);
          chk("dp_b", dp_b, op_b);
          m_in_wait = 1;
          if (m_ctx == drop_ctx || (rnd_drop && $urandom_range(15) == 0)) begin
            done_at = -1;
            tmo_at = cyc + 255;
          end else begin
            done_at = cyc + (lat_fix > 0 ? lat_fix : int'($urandom_range(4, 1)));
            tmo_at = -1;
          end
        end
        if (cyc == done_at) begin
          chk("dp_v_hold", dp_v, op_v);
          chk("dp_b_hold", dp_b, op_b);
          sum = {1'b0, op_v} + {1'b0, op_b};
          cap_v = sum[7:0];
          cap_s = force_spk || sum >= 9'd200;
          skip = 0;
          write_at = cyc + 1;
          m_in_wait = 0;
          dp_done = 1'b1;
          dp_v_nxt = cap_v;
          dp_spike = cap_s;
        end else if (cyc == tmo_at) begin
          tmo_s = 1;
          skip = 1;
          write_at = cyc + 1;
          m_in_wait = 0;
        end else if (!m_busy && $urandom_range(7) == 0) begin
          dp_done = 1'b1;
          dp_v_nxt = 8'($urandom);
          dp_spike = 1'($urandom);
        end
        full = mq.size() == 4;
        pop = mq.size() != 0 && spk_ready;
        push = cyc == write_at && !skip && cap_s;
        if (pop) void'(mq.pop_front());
        if (push) begin
          if (full && !pop) ovf_s = 1;
          else mq.push_back(m_ctx);
        end
        b = m_busy;
        tick = ena && m_tcnt == 15;
        if (cyc == write_at) begin
          if (!skip) begin mv[m_ctx] = cap_v; m_vmon = cap_v; end
          if (m_ctx == 3) m_busy = 0;
          else begin m_ctx++; issue_at = cyc + 1; end
        end
        if (tick) begin
          if (b) ovr_s = 1;
          else begin m_busy = 1; m_ctx = 0; issue_at = cyc + 1; end
        end
        if (ena) m_tcnt = tick ? 0 : m_tcnt + 1;
        if (cfg_we) mb[cfg_addr] = cfg_data;
        m_ovf = ovf_s || (m_ovf && !err_clr);
        m_ovr = ovr_s || (m_ovr && !err_clr);
        m_tmo = tmo_s || (m_tmo && !err_clr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dp_start", dp_start, 0); chk("rst_dp_v", dp_v, 0); chk("rst_dp_b", dp_b, 0);
    chk("rst_spk_valid", spk_valid, 0); chk("rst_spk_id", spk_id, 0); chk("rst_v_mon", v_mon, 0);
    chk("rst_busy", busy, 0); chk("rst_ovf", ovf, 0); chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic tick_once();
    ena = 1'b1;
    step(16);
    ena = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin step(1); n++; end
    chk("idle_bound", busy, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  initial begin
    int n, s0;
    @(posedge clk); #1;
    do_reset();
    // four contexts with 2-cycle datapath
    cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 30); cfg_write(3, 40);
    s0 = starts;
    tick_once();
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(1); n++; end
    chk("busy_len", n, 16);
    chk("starts", starts - s0, 4);
    chk("v_mon_r1", v_mon, 40);
    // spike on context 2 in the second round, held while not ready
    do_reset();
    cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 120); cfg_write(3, 40);
    tick_once(); wait_idle(); tick_once(); wait_idle();
    chk("spk2_valid", spk_valid, 1);
    chk("spk2_id", spk_id, 2);
    step(5);
    chk("spk2_hold", spk_id, 2);
    spk_ready = 1'b1; step(1); spk_ready = 1'b0;
    chk("spk2_gone", spk_valid, 0);
    // FIFO overflow and drain order
    do_reset();
    force_spk = 1;
    tick_once(); wait_idle(); tick_once(); wait_idle();
    chk("ovf_set", ovf, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_id", spk_id, i);
      spk_ready = 1'b1; step(1); spk_ready = 1'b0;
    end
    chk("drain_empty", spk_valid, 0);
    force_spk = 0;
    pulse_clr();
    chk("ovf_clr", ovf, 0);
    // datapath never answers for context 1
    for (int i = 0; i < 4; i++) cfg_write(2'(i), 8'($urandom));
    drop_ctx = 1;
    tick_once(); wait_idle();
    chk("tmo_set", timeout_err, 1);
    drop_ctx = -1;
    tick_once(); wait_idle();
    pulse_clr();
    chk("tmo_clr", timeout_err, 0);
    // overrun with 3-cycle datapath and continuous ticks; set beats clear
    lat_fix = 3;
    ena = 1'b1;
    step(40);
    chk("ovr_set", overrun, 1);
    n = 0;
    while (!(m_tcnt == 15 && m_busy) && n < 64) begin step(1); n++; end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("ovr_wins", overrun, 1);
    ena = 1'b0;
    wait_idle();
    pulse_clr();
    chk("ovr_clr", overrun, 0);
    // reset during WAIT of context 2
    lat_fix = 2;
    tick_once();
    n = 0;
    while (!(m_in_wait && m_ctx == 2) && n < 100) begin step(1); n++; end
    chk("busy_pre_rst", busy, 1);
    do_reset();
    s0 = starts;
    tick_once(); wait_idle();
    chk("starts_post_rst", starts - s0, 4);
    // randomized traffic
    lat_fix = 0;
    rnd_drop = 1;
    for (int i = 0; i < 3000; i++) begin
      ena = $urandom_range(3) != 0;
      spk_ready = $urandom_range(1) == 1;
      err_clr = $urandom_range(15) == 0;
      cfg_we = $urandom_range(3) == 0;
      cfg_addr = 2'($urandom);
      cfg_data = 8'($urandom);
      step(1);
    end
    ena = 1'b0; spk_ready = 1'b0; err_clr = 1'b0; cfg_we = 1'b0; rnd_drop = 0;
    wait_idle();
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
